// File: rtl/nrisc_pkg.sv
// Shared nRISC definitions: opcode encodings, default widths and fetch-unit states.
package nrisc_pkg;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned INSTR_W_DEF = 8;
    localparam int unsigned OPCODE_W    = 3;
    localparam int unsigned COUNT_W     = 16;

    typedef enum logic [OPCODE_W-1:0] {
        OpDefi    = 3'b000,
        OpBeq     = 3'b001,
        OpLw      = 3'b010,
        OpSw      = 3'b011,
        OpMul     = 3'b100,
        OpSubi    = 3'b101,
        OpJ       = 3'b110,
        OpEncerra = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StExec,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: instruction-memory read port, decoder/datapath hooks and status.
interface instr_fetch_if
    import nrisc_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
);

    logic                Start;
    logic                MemReq;
    logic [ADDR_W-1:0]   MemAddr;
    logic                MemAck;
    logic [INSTR_W-1:0]  MemData;
    logic [OPCODE_W-1:0] Istrc;
    logic [INSTR_W-1:0]  Instr;
    logic                InstrValid;
    logic                Jump;
    logic                Branch;
    logic                Encerra;
    logic                Zero;
    logic [ADDR_W-1:0]   JumpTarget;
    logic [ADDR_W-1:0]   BranchTarget;
    logic [ADDR_W-1:0]   PC;
    logic                Halted;
    logic [COUNT_W-1:0]  InstrCount;

    modport master (
        input  Start, MemAck, MemData, Jump, Branch, Encerra, Zero, JumpTarget, BranchTarget,
        output MemReq, MemAddr, Istrc, Instr, InstrValid, PC, Halted, InstrCount
    );

    modport slave (
        output Start, MemAck, MemData, Jump, Branch, Encerra, Zero, JumpTarget, BranchTarget,
        input  MemReq, MemAddr, Istrc, Instr, InstrValid, PC, Halted, InstrCount
    );

endinterface

// File: rtl/pc_next.sv
// Next-PC selection: encerra holds, then jump, then taken beq, else sequential wrap.
module pc_next
    import nrisc_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              jump,
    input  logic              branch,
    input  logic              zero,
    input  logic              encerra,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] next_pc
);

    always_comb begin
        next_pc = pc + ADDR_W'(1);
        if (encerra) begin
            next_pc = pc;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch && zero) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch unit: IDLE -> FETCH <-> EXEC, stopping in HALT on encerra.
module instr_fetch
    import nrisc_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic           Clock,
    input logic           Reset_n,
    instr_fetch_if.master bus
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q;
    logic [COUNT_W-1:0] count_q;
    logic               exec;
    logic               fetch_done;

    assign exec       = (state_q == StExec);
    assign fetch_done = (state_q == StFetch) && bus.MemAck;

    pc_next #(
        .ADDR_W(ADDR_W)
    ) u_pc_next (
        .pc           (pc_q),
        .jump         (bus.Jump),
        .branch       (bus.Branch),
        .zero         (bus.Zero),
        .encerra      (bus.Encerra),
        .jump_target  (bus.JumpTarget),
        .branch_target(bus.BranchTarget),
        .next_pc      (pc_d)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.Start) state_d = StFetch;
            StFetch: if (bus.MemAck) state_d = StExec;
            StExec:  state_d = bus.Encerra ? StHalt : StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.MemReq     = 1'b0;
        bus.InstrValid = 1'b0;
        bus.Halted     = 1'b0;
        unique case (state_q)
            StFetch: bus.MemReq     = 1'b1;
            StExec:  bus.InstrValid = 1'b1;
            StHalt:  bus.Halted     = 1'b1;
            default: ;
        endcase
        bus.MemAddr    = pc_q;
        bus.PC         = pc_q;
        bus.Instr      = instr_q;
        bus.Istrc      = instr_q[INSTR_W-1 -: OPCODE_W];
        bus.InstrCount = count_q;
    end

    // Control inputs are only meaningful during EXEC, so PC and count advance only there.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            count_q <= '0;
        end else begin
            if (fetch_done) begin
                instr_q <= bus.MemData;
            end
            if (exec) begin
                pc_q <= pc_d;
                if (count_q != '1) begin
                    count_q <= count_q + COUNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: fetched words queued on ack, checked when EXEC shows them.
module tb_instr_fetch;
    import nrisc_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned IW = 8;

    logic Clock = 1'b0;
    logic Reset_n;

    instr_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    instr_fetch #(
        .ADDR_W  (AW),
        .INSTR_W (IW),
        .RESET_PC(8'h00)
    ) dut (
        .Clock  (Clock),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    logic [IW-1:0] exp_q[$];
    logic [AW-1:0] exp_pc;
    logic [15:0]   exp_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.Start        = 1'b0;
        bus.MemAck       = 1'b0;
        bus.MemData      = '0;
        bus.Jump         = 1'b0;
        bus.Branch       = 1'b0;
        bus.Encerra      = 1'b0;
        bus.Zero         = 1'b0;
        bus.JumpTarget   = '0;
        bus.BranchTarget = '0;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset_n = 1'b0;
        idle_inputs();
        #1;
        check_eq("rst_req",    32'(bus.MemReq),     32'h0);
        check_eq("rst_valid",  32'(bus.InstrValid), 32'h0);
        check_eq("rst_halted", 32'(bus.Halted),     32'h0);
        check_eq("rst_pc",     32'(bus.PC),         32'h0);
        check_eq("rst_instr",  32'(bus.Instr),      32'h0);
        check_eq("rst_istrc",  32'(bus.Istrc),      32'h0);
        check_eq("rst_count",  32'(bus.InstrCount), 32'h0);
        @(negedge Clock);
        Reset_n = 1'b1;
        exp_pc  = 8'h00;
        exp_cnt = 16'h0000;
        exp_q.delete();
    endtask

    task automatic start_run();
        bus.Start = 1'b1;
        @(negedge Clock);
        bus.Start = 1'b0;
    endtask

    // One full fetch (with 'delay' wait cycles before the ack) followed by its EXEC cycle.
    task automatic fetch_exec(input logic [IW-1:0] word, input int delay,
                              input logic j, input logic b, input logic z, input logic e,
                              input logic [AW-1:0] jt, input logic [AW-1:0] bt,
                              input logic start_noise);
        logic [IW-1:0] ew;
        check_eq("fetch_req",  32'(bus.MemReq),  32'h1);
        check_eq("fetch_addr", 32'(bus.MemAddr), 32'(exp_pc));
        bus.Start = start_noise;
        for (int i = 0; i < delay; i++) begin
            bus.MemAck = 1'b0;
            @(negedge Clock);
            check_eq("req_hold",   32'(bus.MemReq),     32'h1);
            check_eq("addr_hold",  32'(bus.MemAddr),    32'(exp_pc));
            check_eq("wait_valid", 32'(bus.InstrValid), 32'h0);
        end
        bus.MemAck  = 1'b1;
        bus.MemData = word;
        exp_q.push_back(word);
        @(negedge Clock);
        bus.MemAck  = 1'b0;
        bus.MemData = '0;
        check_eq("exec_valid", 32'(bus.InstrValid), 32'h1);
        check_eq("exec_req",   32'(bus.MemReq),     32'h0);
        if (bus.InstrValid === 1'b1 && exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            check_eq("instr", 32'(bus.Instr), 32'(ew));
            check_eq("istrc", 32'(bus.Istrc), 32'(ew[IW-1 -: 3]));
        end
        bus.Jump         = j;
        bus.Branch       = b;
        bus.Zero         = z;
        bus.Encerra      = e;
        bus.JumpTarget   = jt;
        bus.BranchTarget = bt;
        if (e)           exp_pc = exp_pc;
        else if (j)      exp_pc = jt;
        else if (b && z) exp_pc = bt;
        else             exp_pc = exp_pc + 8'h01;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h0001;
        @(negedge Clock);
        idle_inputs();
        check_eq("valid_pulse", 32'(bus.InstrValid), 32'h0);
        check_eq("count",       32'(bus.InstrCount), 32'(exp_cnt));
        check_eq("pc",          32'(bus.PC),         32'(exp_pc));
        check_eq("halted",      32'(bus.Halted),     32'(e));
    endtask

    initial begin
        Reset_n = 1'b0;
        idle_inputs();
        do_reset();

        // No fetch until Start.
        repeat (3) begin
            @(negedge Clock);
            check_eq("idle_req", 32'(bus.MemReq), 32'h0);
        end
        start_run();

        fetch_exec(8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        fetch_exec(8'hA1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        fetch_exec(8'h42, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        check_eq("count_three", 32'(bus.InstrCount), 32'h3);

        fetch_exec(8'h60, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        fetch_exec(8'hC0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h20, 8'h40, 1'b0);
        fetch_exec(8'h21, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 1'b0);
        fetch_exec(8'h22, 1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 8'hFF, 1'b0);
        fetch_exec(8'h80, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        fetch_exec(8'hC5, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00, 1'b0);
        fetch_exec(8'hE0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h30, 8'h40, 1'b0);

        // Halted: Start and MemAck must both be ignored.
        bus.Start   = 1'b1;
        bus.MemAck  = 1'b1;
        bus.MemData = 8'h55;
        repeat (4) begin
            @(negedge Clock);
            check_eq("halt_flag",  32'(bus.Halted),     32'h1);
            check_eq("halt_req",   32'(bus.MemReq),     32'h0);
            check_eq("halt_valid", 32'(bus.InstrValid), 32'h0);
            check_eq("halt_pc",    32'(bus.PC),         32'h05);
            check_eq("halt_instr", 32'(bus.Instr),      32'hE0);
            check_eq("halt_count", 32'(bus.InstrCount), 32'(exp_cnt));
        end
        idle_inputs();

        // Saturating retire counter.
        do_reset();
        start_run();
        force dut.count_q = 16'hFFFF;
        @(negedge Clock);
        release dut.count_q;
        exp_cnt = 16'hFFFF;
        @(negedge Clock);
        check_eq("sat_preload", 32'(bus.InstrCount), 32'hFFFF);
        fetch_exec(8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Asynchronous reset during a pending fetch; a late ack must be ignored.
        do_reset();
        start_run();
        fetch_exec(8'h42, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        check_eq("pre_rst_req", 32'(bus.MemReq), 32'h1);
        #2;
        Reset_n = 1'b0;
        #1;
        check_eq("async_req",   32'(bus.MemReq),     32'h0);
        check_eq("async_pc",    32'(bus.PC),         32'h0);
        check_eq("async_count", 32'(bus.InstrCount), 32'h0);
        check_eq("async_instr", 32'(bus.Instr),      32'h0);
        @(negedge Clock);
        Reset_n     = 1'b1;
        bus.MemAck  = 1'b1;
        bus.MemData = 8'h99;
        repeat (2) begin
            @(negedge Clock);
            check_eq("late_ack_req",   32'(bus.MemReq),     32'h0);
            check_eq("late_ack_valid", 32'(bus.InstrValid), 32'h0);
            check_eq("late_ack_instr", 32'(bus.Instr),      32'h0);
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
